// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES inverse cipher, one 128-bit block per transaction
// Ports:
//   i_clk, i_rst_n              clock (rising edge), asynchronous active-low reset
//   i_in_valid / o_in_ready     ciphertext handshake, i_in_data[127:120] = byte 0 (FIPS-197 order)
//   o_rk_addr / i_rk_data       round key index (0..NR) and its key, combinational external store
//   o_out_valid / i_out_ready   plaintext handshake, o_out_data driven straight from the state register
module aes_inv_cipher_iter #(
    parameter int NR       = 10,
    parameter int SB_LANES = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [127:0] i_in_data,
    output logic [3:0]   o_rk_addr,
    input  logic [127:0] i_rk_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [127:0] o_out_data
);
    localparam int P  = 16 / SB_LANES;
    localparam int KW = (P > 1) ? $clog2(P) : 1;

    if (!(NR == 10 || NR == 12 || NR == 14) || !(SB_LANES == 16 || SB_LANES == 8 || SB_LANES == 4)) begin : g_bad_param
        $error("aes_inv_cipher_iter: NR must be 10/12/14 and SB_LANES 16/8/4");
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xt(x);
        end
        return p;
    endfunction

    // Inverse affine map, then the field inverse as y^254 (maps 0 to 0 for free).
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a, y;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        y = a;
        for (int i = 0; i < 6; i++)
            y = gmul(gmul(y, y), a);
        return gmul(y, y);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
        return o;
    endfunction

    // 0E/0B/0D/09 built from the x2/x4/x8 xtime chain of each byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4], m2 [4], m4 [4], m8 [4];
        logic [31:0] o;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31 - 8 * i -: 8];
            m2[i] = xt(a[i]);
            m4[i] = xt(m2[i]);
            m8[i] = xt(m4[i]);
        end
        for (int i = 0; i < 4; i++)
            o[31 - 8 * i -: 8] = (m8[i] ^ m4[i] ^ m2[i])
                               ^ (m8[(i + 1) % 4] ^ m2[(i + 1) % 4] ^ a[(i + 1) % 4])
                               ^ (m8[(i + 2) % 4] ^ m4[(i + 2) % 4] ^ a[(i + 2) % 4])
                               ^ (m8[(i + 3) % 4] ^ a[(i + 3) % 4]);
        return o;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_SUB, S_KEY, S_DONE} state_t;

    state_t          r_fsm, w_fsm_nxt;
    logic [127:0]    r_state, w_state_nxt, w_sub, w_key, w_mix;
    logic [3:0]      r_round, w_round_nxt;
    logic [KW-1:0]   r_lane, w_lane_nxt;
    logic            r_out_valid, w_out_valid_nxt;

    // Only the SB_LANES bytes of the current lane group pass through an InvSBox this cycle.
    always_comb begin
        w_sub = r_state;
        for (int b = 0; b < SB_LANES; b++)
            w_sub[127 - 8 * (int'(r_lane) * SB_LANES + b) -: 8] =
                inv_sbox(r_state[127 - 8 * (int'(r_lane) * SB_LANES + b) -: 8]);
    end

    // InvShiftRows is applied here rather than before SUB; it commutes with InvSubBytes.
    always_comb begin
        w_key = inv_shift_rows(r_state) ^ i_rk_data;
        w_mix = w_key;
        for (int c = 0; c < 4; c++)
            w_mix[127 - 32 * c -: 32] = inv_mix_col(w_key[127 - 32 * c -: 32]);
    end

    always_comb begin
        w_fsm_nxt       = r_fsm;
        w_state_nxt     = r_state;
        w_round_nxt     = r_round;
        w_lane_nxt      = r_lane;
        w_out_valid_nxt = r_out_valid;
        o_in_ready      = 1'b0;
        o_rk_addr       = 4'(NR);
        case (r_fsm)
            S_IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_state_nxt = i_in_data ^ i_rk_data;
                    w_round_nxt = 4'(NR - 1);
                    w_lane_nxt  = '0;
                    w_fsm_nxt   = S_SUB;
                end
            end
            S_SUB: begin
                o_rk_addr   = r_round;
                w_state_nxt = w_sub;
                w_lane_nxt  = r_lane + 1'b1;
                if (r_lane == KW'(P - 1))
                    w_fsm_nxt = S_KEY;
            end
            S_KEY: begin
                o_rk_addr  = r_round;
                w_lane_nxt = '0;
                if (r_round == 4'd0) begin
                    w_state_nxt     = w_key;
                    w_out_valid_nxt = 1'b1;
                    w_fsm_nxt       = S_DONE;
                end else begin
                    w_state_nxt = w_mix;
                    w_round_nxt = r_round - 4'd1;
                    w_fsm_nxt   = S_SUB;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_round_nxt     = 4'(NR);
                    w_fsm_nxt       = S_IDLE;
                end
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_round     <= 4'(NR);
            r_lane      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_state     <= w_state_nxt;
            r_round     <= w_round_nxt;
            r_lane      <= w_lane_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_state;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter: round-trip bench for aes_inv_cipher_iter against a forward-cipher model
module tb_aes_inv_cipher_iter;
    localparam int NRS [3] = '{10, 10, 14};
    localparam int PS  [3] = '{1, 4, 1};
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PTKAT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid [3];
    logic         in_ready [3];
    logic [127:0] in_data  [3];
    logic [3:0]   rk_addr  [3];
    logic [127:0] rk_data  [3];
    logic         out_valid[3];
    logic         out_ready[3];
    logic [127:0] out_data [3];
    logic         noise    [3];
    logic [127:0] noise_val;
    logic [127:0] rk [3][16];
    logic [7:0]   sbox [256];
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    // The key store; noise replaces it in cycles where the block must not look at it.
    assign rk_data[0] = noise[0] ? noise_val : rk[0][rk_addr[0]];
    assign rk_data[1] = noise[1] ? noise_val : rk[1][rk_addr[1]];
    assign rk_data[2] = noise[2] ? noise_val : rk[2][rk_addr[2]];

    aes_inv_cipher_iter #(.NR(10), .SB_LANES(16)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
        .i_in_data(in_data[0]), .o_rk_addr(rk_addr[0]), .i_rk_data(rk_data[0]),
        .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]), .o_out_data(out_data[0]));
    aes_inv_cipher_iter #(.NR(10), .SB_LANES(4)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
        .i_in_data(in_data[1]), .o_rk_addr(rk_addr[1]), .i_rk_data(rk_data[1]),
        .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]), .o_out_data(out_data[1]));
    aes_inv_cipher_iter #(.NR(14), .SB_LANES(16)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]),
        .i_in_data(in_data[2]), .o_rk_addr(rk_addr[2]), .i_rk_data(rk_data[2]),
        .o_out_valid(out_valid[2]), .i_out_ready(out_ready[2]), .o_out_data(out_data[2]));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Carry-less product reduced by long division with 0x11B.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] v;
        for (int x = 0; x < 256; x++) begin
            v = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            sbox[x] = v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input int d, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        nk = NRS[d] - 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (NRS[d] + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int j = 0; j <= NRS[d]; j++) rk[d][j] = {w[4 * j], w[4 * j + 1], w[4 * j + 2], w[4 * j + 3]};
    endtask

    // Forward cipher with the instance's key schedule; decryption must undo it.
    function automatic logic [127:0] encrypt(input int d, input logic [127:0] pt);
        logic [7:0] s [16], t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ rk[d][0][127 - 8 * i -: 8];
        for (int rd = 1; rd <= NRS[d]; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4 * c + r] = s[4 * ((c + r) % 4) + r];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4 * c + r] = (rd == NRS[d]) ? t[4 * c + r] :
                        gm(8'h02, t[4 * c + r]) ^ gm(8'h03, t[4 * c + (r + 1) % 4])
                        ^ t[4 * c + (r + 2) % 4] ^ t[4 * c + (r + 3) % 4];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[d][rd][127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
        return o;
    endfunction

    // Accept ct, follow the rk_addr sequence, measure latency, check the plaintext.
    task automatic run_block(input int d, input logic [127:0] ct, input logic [127:0] pt,
                             input bit nz, input string tag);
        int lat;
        chk({tag, "_in_ready"}, 128'(in_ready[d]), 128'(1));
        chk({tag, "_rk_idle"}, 128'(rk_addr[d]), 128'(NRS[d]));
        in_valid[d] = 1'b1;
        in_data[d]  = ct;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_data[d]  = {$urandom, $urandom, $urandom, $urandom};
        chk({tag, "_busy"}, 128'(in_ready[d]), 128'(0));
        lat = 0;
        while (!out_valid[d] && lat < 300) begin
            chk($sformatf("%s_rk_addr_%0d", tag, lat), 128'(rk_addr[d]),
                128'(NRS[d] - 1 - lat / (PS[d] + 1)));
            noise[d]  = nz && (lat % (PS[d] + 1) != PS[d]);
            noise_val = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            lat++;
        end
        noise[d] = 1'b0;
        chk({tag, "_latency"}, 128'(lat), 128'(NRS[d] * (PS[d] + 1)));
        chk({tag, "_data"}, out_data[d], pt);
        chk({tag, "_done_ready"}, 128'(in_ready[d]), 128'(0));
    endtask

    task automatic release_blk(input int d, input string tag);
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_rel_valid"}, 128'(out_valid[d]), 128'(0));
        chk({tag, "_rel_ready"}, 128'(in_ready[d]), 128'(1));
        out_ready[d] = 1'b0;
    endtask

    initial begin
        logic [127:0] pt, ct;
        int hold;
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0; noise[d] = 1'b0;
        end
        noise_val = '0;
        #2 rst_n = 1'b0;
        build_sbox();
        expand(0, K128);
        expand(1, K128);
        expand(2, K256);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_valid_%0d", d), 128'(out_valid[d]), 128'(0));
            chk($sformatf("rst_data_%0d", d), out_data[d], 128'(0));
            chk($sformatf("rst_rk_%0d", d), 128'(rk_addr[d]), 128'(NRS[d]));
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) chk($sformatf("rst_ready_%0d", d), 128'(in_ready[d]), 128'(1));

        // Known answers; out_ready held high gives a one-cycle DONE.
        out_ready[0] = 1'b1;
        run_block(0, CT128, PTKAT, 1'b0, "kat128");
        release_blk(0, "kat128");
        out_ready[1] = 1'b1;
        run_block(1, CT128, PTKAT, 1'b1, "kat128_p4");
        release_blk(1, "kat128_p4");
        out_ready[2] = 1'b1;
        run_block(2, CT256, PTKAT, 1'b0, "kat256");
        release_blk(2, "kat256");

        // Backpressure in DONE with a second block already offered.
        pt = {$urandom, $urandom, $urandom, $urandom};
        ct = encrypt(0, pt);
        run_block(0, CT128, PTKAT, 1'b0, "bp");
        in_valid[0] = 1'b1;
        in_data[0]  = ct;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_data_%0d", i), out_data[0], PTKAT);
            chk($sformatf("bp_hold_ready_%0d", i), 128'(in_ready[0]), 128'(0));
            chk($sformatf("bp_hold_valid_%0d", i), 128'(out_valid[0]), 128'(1));
        end
        release_blk(0, "bp");
        run_block(0, ct, pt, 1'b0, "bp_queued");
        release_blk(0, "bp_queued");

        // Reset in the middle of a block.
        in_valid[0] = 1'b1;
        in_data[0]  = CT128;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_rk_round5", 128'(rk_addr[0]), 128'(5));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(out_valid[0]), 128'(0));
        chk("arst_data", out_data[0], 128'(0));
        chk("arst_ready", 128'(in_ready[0]), 128'(1));
        chk("arst_rk", 128'(rk_addr[0]), 128'(10));
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_rel_ready", 128'(in_ready[0]), 128'(1));
        run_block(0, CT128, PTKAT, 1'b0, "post_rst");
        release_blk(0, "post_rst");

        // Random keys and blocks, random sink stalls.
        for (int d = 0; d < 3; d++) begin
            expand(d, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            for (int n = 0; n < 3; n++) begin
                pt = {$urandom, $urandom, $urandom, $urandom};
                ct = encrypt(d, pt);
                out_ready[d] = 1'($urandom_range(0, 1));
                run_block(d, ct, pt, d == 1, $sformatf("rnd_%0d_%0d", d, n));
                hold = out_ready[d] ? 0 : int'($urandom_range(0, 3));
                for (int i = 0; i < hold; i++) begin
                    @(posedge clk); #1;
                    chk($sformatf("rnd_hold_%0d_%0d_%0d", d, n, i), out_data[d], pt);
                end
                release_blk(d, $sformatf("rnd_%0d_%0d", d, n));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
